y_id_ex_dm: RTL and testbench

Y_ID_EX_DM -- requirements
Module: y_id_ex_dm

---
 rtl/y_id_ex_dm.sv | 119 +++++++++++
 tb/tb_y_id_ex_dm.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/y_id_ex_dm.sv
// rtl/y_id_ex_dm.sv - decode/execute/data-memory slice: register file, immediates, ALU, data RAM
// Optional signed set-less-than on op 111 is enabled by defining Y_SLT_EN.
module y_id_ex_dm #(
    parameter int DM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ins,
    input  logic [31:0] wd,
    input  logic        RegWrite,
    input  logic [2:0]  op,
    input  logic        ALUSrc,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [31:0] imm,
    output logic [31:0] branch,
    output logic [31:0] jTarget,
    output logic [31:0] z,
    output logic        zero,
    output logic [31:0] memOut
);

    localparam int AW = $clog2(DM_WORDS);

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    logic [31:0] regs_q [32];
    logic [31:0] mem_q  [DM_WORDS];

    logic [4:0]    rs1_a;
    logic [4:0]    rs2_a;
    logic [4:0]    rd_a;
    logic          reg_we_d;
    logic          mem_we_d;
    logic [AW-1:0] dm_idx;
    logic [31:0]   alu_a;
    logic [31:0]   alu_b;
    logic [31:0]   z_d;
    logic          unused_funct3;

    assign rs1_a = ins[19:15];
    assign rs2_a = ins[24:20];
    assign rd_a  = ins[11:7];

    assign unused_funct3 = ^ins[14:12];

    // x0 is hardwired: read it as zero and never let a write land there.
    assign rd1 = (rs1_a == 5'd0) ? 32'd0 : regs_q[rs1_a];
    assign rd2 = (rs2_a == 5'd0) ? 32'd0 : regs_q[rs2_a];

    assign reg_we_d = RegWrite && (rd_a != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (reg_we_d) begin
            regs_q[rd_a] <= wd;
        end
    end

    // Offsets stay in halfword units; the PC adder downstream does the shift.
    assign branch  = {{20{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8]};
    assign jTarget = {{12{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21]};

    always_comb begin
        imm = 32'd0;
        case (ins[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_JALR: imm = {{20{ins[31]}}, ins[31:20]};
            OPC_STORE:                     imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            OPC_BRANCH:                    imm = branch;
            OPC_JAL:                       imm = jTarget;
            default:                       imm = 32'd0;
        endcase
    end

    assign alu_a = rd1;
    assign alu_b = ALUSrc ? imm : rd2;

    always_comb begin
        z_d = 32'd0;
        case (op)
            3'b000:  z_d = alu_a & alu_b;
            3'b001:  z_d = alu_a | alu_b;
            3'b010:  z_d = alu_a + alu_b;
            3'b110:  z_d = alu_a - alu_b;
`ifdef Y_SLT_EN
            3'b111:  z_d = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
`else
            3'b111:  z_d = 32'd0;
`endif
            default: z_d = 32'd0;
        endcase
    end

    assign z    = z_d;
    assign zero = (z_d == 32'd0);

    // Word index only; byte offset is dropped and high bits alias modulo depth.
    assign dm_idx   = z_d[AW+1:2];
    assign mem_we_d = MemWrite && !rst;

    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem_q[dm_idx] <= rd2;
        end
    end

    assign memOut = MemRead ? mem_q[dm_idx] : 32'd0;

endmodule

// File: tb/tb_y_id_ex_dm.sv
// tb/tb_y_id_ex_dm.sv - scoreboard bench for y_id_ex_dm with directed vectors
module tb_y_id_ex_dm;

    localparam int S_RD1 = 0;
    localparam int S_RD2 = 1;
    localparam int S_IMM = 2;
    localparam int S_BR  = 3;
    localparam int S_JT  = 4;
    localparam int S_Z   = 5;
    localparam int S_ZR  = 6;
    localparam int S_MEM = 7;

    localparam logic [6:0] OPC_R = 7'h33;

    logic        clk;
    logic        rst;
    logic [31:0] ins;
    logic [31:0] wd;
    logic        RegWrite;
    logic [2:0]  op;
    logic        ALUSrc;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] branch;
    logic [31:0] jTarget;
    logic [31:0] z;
    logic        zero;
    logic [31:0] memOut;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    y_id_ex_dm #(.DM_WORDS(1024)) dut (
        .clk(clk), .rst(rst), .ins(ins), .wd(wd), .RegWrite(RegWrite), .op(op),
        .ALUSrc(ALUSrc), .MemRead(MemRead), .MemWrite(MemWrite), .rd1(rd1), .rd2(rd2),
        .imm(imm), .branch(branch), .jTarget(jTarget), .z(z), .zero(zero), .memOut(memOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] r_ins(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [6:0] opc);
        return {7'd0, rs2, rs1, 3'b000, rd, opc};
    endfunction

    function automatic logic [31:0] i_ins(input logic [11:0] im, input logic [4:0] rs1,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {im, rs1, 3'b010, rd, opc};
    endfunction

    function automatic logic [31:0] s_ins(input logic [11:0] im, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] b_ins(input logic [11:0] f, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {f[11], f[9:4], rs2, rs1, 3'b000, f[3:0], f[10], 7'h63};
    endfunction

    task automatic expect_val(input string name, input int sel, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [4:0] rd, input logic [31:0] val);
        ins      = r_ins(rd, 5'd0, 5'd0, OPC_R);
        wd       = val;
        RegWrite = 1'b1;
        step();
        RegWrite = 1'b0;
    endtask

    // Monitor: outputs are combinational, so they are valid at every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                exp_t e;
                logic [31:0] act;
                e = sb.pop_front();
                case (e.sel)
                    S_RD1:   act = rd1;
                    S_RD2:   act = rd2;
                    S_IMM:   act = imm;
                    S_BR:    act = branch;
                    S_JT:    act = jTarget;
                    S_Z:     act = z;
                    S_ZR:    act = {31'd0, zero};
                    default: act = memOut;
                endcase
                checks++;
                if (act !== e.val) begin
                    errors++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
                end
            end
        end
    end

    initial begin
        logic [31:0] alu_exp [8];
        logic [31:0] slt_t;
        int          budget;

`ifdef Y_SLT_EN
        slt_t = 32'd1;
`else
        slt_t = 32'd0;
`endif
        alu_exp[0] = 32'h0000_0000;
        alu_exp[1] = 32'h0000_00FF;
        alu_exp[2] = 32'h0000_00FF;
        alu_exp[3] = 32'h0000_0000;
        alu_exp[4] = 32'h0000_0000;
        alu_exp[5] = 32'h0000_0000;
        alu_exp[6] = 32'hFFFF_FF1F;
        alu_exp[7] = slt_t;

        rst = 1'b1; ins = 32'd0; wd = 32'd0; RegWrite = 1'b0; op = 3'b000;
        ALUSrc = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        step();

        // Reset wins over a simultaneous register write
        RegWrite = 1'b1; wd = 32'h0000_1234; ins = r_ins(5'd5, 5'd5, 5'd5, OPC_R);
        step();
        rst = 1'b0; RegWrite = 1'b0; op = 3'b010;
        expect_val("rst_rd1", S_RD1, 32'd0);
        expect_val("rst_rd2", S_RD2, 32'd0);
        expect_val("rst_mem", S_MEM, 32'd0);
        expect_val("rst_imm", S_IMM, 32'd0);
        expect_val("rst_z", S_Z, 32'd0);
        expect_val("rst_zero", S_ZR, 32'd1);
        step();

        // Old value visible until the write edge
        ins = r_ins(5'd5, 5'd5, 5'd0, OPC_R); wd = 32'd7; RegWrite = 1'b1;
        expect_val("wr_old", S_RD1, 32'd0);
        step();
        RegWrite = 1'b0;
        expect_val("x5_rd1", S_RD1, 32'd7);
        step();

        wr_reg(5'd0, 32'hFFFF_FFFF);
        ins = r_ins(5'd0, 5'd0, 5'd5, OPC_R);
        expect_val("x0_rd1", S_RD1, 32'd0);
        expect_val("x5_rd2", S_RD2, 32'd7);
        step();

        wr_reg(5'd6, 32'd7);
        wr_reg(5'd7, 32'h0000_000F);
        wr_reg(5'd8, 32'h0000_00F0);
        wr_reg(5'd10, 32'h0000_1000);
        wr_reg(5'd11, 32'hFFFF_FFFF);

        // addi x5, x0, -1
        ins = 32'hFFF0_0293; ALUSrc = 1'b1; op = 3'b010;
        expect_val("addi_imm", S_IMM, 32'hFFFF_FFFF);
        expect_val("addi_z", S_Z, 32'hFFFF_FFFF);
        expect_val("addi_zero", S_ZR, 32'd0);
        step();

        // sw x5, 0x14(x0)
        ins = s_ins(12'h014, 5'd5, 5'd0); MemWrite = 1'b1;
        expect_val("sw_imm", S_IMM, 32'h0000_0014);
        expect_val("sw_z", S_Z, 32'h0000_0014);
        step();
        MemWrite = 1'b0;

        ins = i_ins(12'h014, 5'd0, 5'd9, 7'h03); MemRead = 1'b1;
        expect_val("lw_mem", S_MEM, 32'd7);
        step();
        MemRead = 1'b0;
        expect_val("lw_noread", S_MEM, 32'd0);
        step();

        // Byte offset ignored, and high address bits alias
        ins = i_ins(12'h017, 5'd0, 5'd9, 7'h03); MemRead = 1'b1;
        expect_val("lw_misal_z", S_Z, 32'h0000_0017);
        expect_val("lw_misal_mem", S_MEM, 32'd7);
        step();
        ins = i_ins(12'h014, 5'd10, 5'd9, 7'h03);
        expect_val("lw_wrap_z", S_Z, 32'h0000_1014);
        expect_val("lw_wrap_mem", S_MEM, 32'd7);
        step();

        // Simultaneous read and write: old data seen, new data after the edge
        ins = s_ins(12'h014, 5'd8, 5'd0); MemWrite = 1'b1; MemRead = 1'b1;
        expect_val("rw_old", S_MEM, 32'd7);
        step();
        MemWrite = 1'b0;
        ins = i_ins(12'h014, 5'd0, 5'd9, 7'h03);
        expect_val("rw_new", S_MEM, 32'h0000_00F0);
        step();
        MemRead = 1'b0;

        ins = s_ins(12'hFF8, 5'd5, 5'd0);
        expect_val("sw_neg_imm", S_IMM, 32'hFFFF_FFF8);
        step();

        // beq x5, x6, -4
        ins = b_ins(12'hFFE, 5'd6, 5'd5); ALUSrc = 1'b0; op = 3'b110;
        expect_val("beq_z", S_Z, 32'd0);
        expect_val("beq_zero", S_ZR, 32'd1);
        expect_val("beq_branch", S_BR, 32'hFFFF_FFFE);
        expect_val("beq_imm", S_IMM, 32'hFFFF_FFFE);
        step();

        ins = 32'h0080_006F;
        expect_val("jal_jt", S_JT, 32'd4);
        expect_val("jal_imm", S_IMM, 32'd4);
        step();

        ins = r_ins(5'd0, 5'd7, 5'd8, OPC_R); ALUSrc = 1'b0;
        for (int k = 0; k < 8; k++) begin
            op = 3'(k);
            expect_val($sformatf("alu_op%0d", k), S_Z, alu_exp[k]);
            step();
        end

        ALUSrc = 1'b1; op = 3'b010;
        expect_val("rtype_imm", S_IMM, 32'd0);
        expect_val("rtype_z", S_Z, 32'h0000_000F);
        step();

        ALUSrc = 1'b0;
        ins = r_ins(5'd0, 5'd11, 5'd5, OPC_R);
        expect_val("add_wrap", S_Z, 32'd6);
        step();
        op = 3'b111;
        expect_val("slt_neg", S_Z, slt_t);
        step();
        ins = r_ins(5'd0, 5'd5, 5'd11, OPC_R);
        expect_val("slt_pos", S_Z, 32'd0);
        expect_val("slt_pos_zero", S_ZR, 32'd1);
        step();

        // Second reset clears the whole register file
        rst = 1'b1; step();
        rst = 1'b0;
        ins = r_ins(5'd0, 5'd7, 5'd8, OPC_R);
        expect_val("rst2_rd1", S_RD1, 32'd0);
        expect_val("rst2_rd2", S_RD2, 32'd0);
        step();

        budget = 0;
        while (sb.size() > 0 && budget < 10) begin
            step();
            budget++;
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not end, expected completion");
        $fatal(1);
    end

endmodule
